inverter: RTL and testbench

//   Bitwise logic inverter for a WIDTH-bit bus.
//   - Combinational path: y = ~a, zero latency.
//   - Registered path: y_q, one clock of latency, with a valid flag.
//   - Input-change detection: pulse plus saturating change counter, used as

---
 rtl/inverter_pkg.sv | 9 +
 rtl/inverter_bit.sv | 27 ++
 rtl/inverter.sv | 77 +++++++
 tb/tb_inverter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/inverter_pkg.sv
// Shared defaults for the inverter block: bus width, change-counter width
// and the counter saturation value that goes with the default width.
package inverter_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;
    localparam logic [DEF_CNT_W-1:0] DEF_CNT_MAX = {DEF_CNT_W{1'b1}};

endpackage : inverter_pkg

// File: rtl/inverter_bit.sv
// One-bit inverter cell: combinational inverse plus a registered inverse
// that clears on a synchronous active-low reset.
module inverter_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    output logic y,
    output logic y_q
);

    logic y_q_reg;

    // Combinational path ignores clock and reset; X/Z on a stays X on y.
    assign y = ~a;

    // Registered inverse, one edge of latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q_reg <= 1'b0;
        end else begin
            y_q_reg <= ~a;
        end
    end

    assign y_q = y_q_reg;

endmodule : inverter_bit

// File: rtl/inverter.sv
// WIDTH-bit inverter with a combinational output, a registered output with a
// sticky valid flag, and input-change statistics (pulse plus saturating
// counter) for activity debug.
module inverter
    import inverter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             y_vld,
    output logic             a_chg,
    output logic [CNT_W-1:0] chg_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             y_vld_reg;
    logic             first_reg;
    logic [WIDTH-1:0] a_prev_reg;
    logic             a_chg_reg;
    logic             a_chg_next;
    logic [CNT_W-1:0] chg_cnt_reg;
    logic [CNT_W-1:0] chg_cnt_next;

    // Data path: one cell per bit, each with its own comb and registered inverse.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            inverter_bit u_bit (
                .clk   (clk),
                .rst_n (rst_n),
                .a     (a[gi]),
                .y     (y[gi]),
                .y_q   (y_q[gi])
            );
        end
    endgenerate

    // Change detect: the first sample after reset has no predecessor, so it
    // never flags; the counter sticks at its maximum instead of wrapping.
    always_comb begin
        a_chg_next   = 1'b0;
        chg_cnt_next = chg_cnt_reg;
        if (!first_reg) begin
            a_chg_next = (a != a_prev_reg);
        end
        if (a_chg_next && (chg_cnt_reg != CNT_MAX)) begin
            chg_cnt_next = chg_cnt_reg + 1'b1;
        end
    end

    // Status state: valid flag, first-sample marker, previous sample and stats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_vld_reg   <= 1'b0;
            first_reg   <= 1'b1;
            a_prev_reg  <= '0;
            a_chg_reg   <= 1'b0;
            chg_cnt_reg <= '0;
        end else begin
            y_vld_reg   <= 1'b1;
            first_reg   <= 1'b0;
            a_prev_reg  <= a;
            a_chg_reg   <= a_chg_next;
            chg_cnt_reg <= chg_cnt_next;
        end
    end

    assign y_vld   = y_vld_reg;
    assign a_chg   = a_chg_reg;
    assign chg_cnt = chg_cnt_reg;

endmodule : inverter

// File: tb/tb_inverter.sv
// Self-checking bench for inverter: a history-based model checked every cycle
// on two instances (default counter width and a 2-bit counter), plus directed
// literal expectations.
module tb_inverter;

    logic       clk;
    logic       clk_en;
    logic       rst_n;
    logic [3:0] a;

    logic [3:0] y, y_q;
    logic       y_vld, a_chg;
    logic [7:0] chg_cnt;

    logic [3:0] y2, y_q2;
    logic       y_vld2, a_chg2;
    logic [1:0] chg_cnt2;

    int checks   = 0;
    int failures = 0;

    inverter #(.WIDTH(4), .CNT_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .y       (y),
        .y_q     (y_q),
        .y_vld   (y_vld),
        .a_chg   (a_chg),
        .chg_cnt (chg_cnt)
    );

    inverter #(.WIDTH(4), .CNT_W(2)) dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .y       (y2),
        .y_q     (y_q2),
        .y_vld   (y_vld2),
        .a_chg   (a_chg2),
        .chg_cnt (chg_cnt2)
    );

    // Gated clock so the combinational sweep can run with no edges at all.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: list of samples taken since the last reset edge.
    logic [3:0] hist[$];
    bit         model_valid = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            hist.delete();
            model_valid = 1;
        end else begin
            hist.push_back(a);
        end
    end

    function automatic int count_changes(input int sat);
        int n = 0;
        for (int i = 1; i < hist.size(); i++) begin
            if (hist[i] != hist[i-1]) n++;
        end
        return (n > sat) ? sat : n;
    endfunction

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        logic [3:0] exp_yq;
        logic [3:0] exp_y;
        logic       exp_vld;
        logic       exp_chg;
        if (model_valid) begin
            exp_vld = (hist.size() > 0);
            exp_yq  = exp_vld ? ~hist[hist.size()-1] : 4'b0000;
            exp_chg = (hist.size() >= 2) && (hist[hist.size()-1] != hist[hist.size()-2]);
            exp_y   = ~a;
            check("m_y",        y,        exp_y);
            check("m_y_q",      y_q,      exp_yq);
            check("m_y_vld",    y_vld,    exp_vld);
            check("m_a_chg",    a_chg,    exp_chg);
            check("m_chg_cnt",  chg_cnt,  count_changes(255));
            check("m2_y_q",     y_q2,     exp_yq);
            check("m2_y_vld",   y_vld2,   exp_vld);
            check("m2_a_chg",   a_chg2,   exp_chg);
            check("m2_chg_cnt", chg_cnt2, count_changes(3));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] na;
        clk_en = 1'b0;
        rst_n  = 1'b0;
        a      = 4'b0000;

        // Combinational sweep with the clock stopped.
        for (int i = 0; i < 16; i++) begin
            a = 4'(i);
            #1;
            na = ~a;
            check("sweep_y", y, na);
        end
        $display("sweep: 16 codes applied with clock stopped");

        // Reset held for two edges.
        a = 4'b1010;
        clk_en = 1'b1;
        tick();
        tick();
        check("rst_y_q",    y_q,     4'b0000);
        check("rst_y_vld",  y_vld,   1'b0);
        check("rst_chg",    a_chg,   1'b0);
        check("rst_cnt",    chg_cnt, 8'd0);
        check("rst_y",      y,       4'b0101);
        $display("reset: a=1010 y=%b y_q=%b vld=%b cnt=%0d", y, y_q, y_vld, chg_cnt);

        // Release coincident with a change of a: first sample, no pulse.
        rst_n = 1'b1;
        a     = 4'b1110;
        #1;
        check("t1_y_comb", y, 4'b0001);
        tick();
        check("t1_y_q",   y_q,     4'b0001);
        check("t1_vld",   y_vld,   1'b1);
        check("t1_chg",   a_chg,   1'b0);
        check("t1_cnt",   chg_cnt, 8'd0);
        $display("release: a=1110 y_q=%b vld=%b chg=%b cnt=%0d", y_q, y_vld, a_chg, chg_cnt);

        a = 4'b0001;
        tick();
        check("t2_y_q", y_q,     4'b1110);
        check("t2_chg", a_chg,   1'b1);
        check("t2_cnt", chg_cnt, 8'd1);
        $display("change: a=0001 y_q=%b chg=%b cnt=%0d", y_q, a_chg, chg_cnt);

        tick();
        check("t3_chg", a_chg,   1'b0);
        check("t3_cnt", chg_cnt, 8'd1);
        $display("hold: a=0001 chg=%b cnt=%0d", a_chg, chg_cnt);

        // Random samples, checked by the model every cycle.
        for (int i = 0; i < 25; i++) begin
            a = 4'($urandom_range(0, 15));
            tick();
            $display("random: a=%b y_q=%b chg=%b cnt=%0d", a, y_q, a_chg, chg_cnt);
        end

        // Fresh reset, then toggle: 2-bit counter saturates at 3.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        a = 4'b0101;
        tick();
        for (int i = 0; i < 6; i++) begin
            a = ~a;
            tick();
            $display("toggle: a=%b cnt=%0d cnt2=%0d", a, chg_cnt, chg_cnt2);
        end
        check("sat2_cnt2", chg_cnt2, 2'd3);
        check("sat2_cnt",  chg_cnt,  8'd6);

        // Reset mid-toggle: registered outputs clear, comb path keeps tracking.
        a = ~a;
        rst_n = 1'b0;
        tick();
        na = ~a;
        check("mid_y_q",  y_q,      4'b0000);
        check("mid_vld",  y_vld,    1'b0);
        check("mid_chg",  a_chg,    1'b0);
        check("mid_cnt",  chg_cnt,  8'd0);
        check("mid_cnt2", chg_cnt2, 2'd0);
        check("mid_y",    y,        na);
        $display("mid-reset: a=%b y=%b y_q=%b cnt=%0d", a, y, y_q, chg_cnt);

        rst_n = 1'b1;
        a = ~a;
        tick();
        check("rel2_chg", a_chg, 1'b0);
        check("rel2_vld", y_vld, 1'b1);

        // Long toggle run: 8-bit counter must stop at 255.
        for (int i = 0; i < 300; i++) begin
            a = ~a;
            tick();
        end
        check("sat8_cnt",  chg_cnt,  8'd255);
        check("sat8_cnt2", chg_cnt2, 2'd3);
        a = ~a;
        tick();
        check("sat8_hold", chg_cnt, 8'd255);
        check("sat8_chg",  a_chg,   1'b1);
        $display("saturate: cnt=%0d cnt2=%0d chg=%b", chg_cnt, chg_cnt2, a_chg);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_inverter
